bmp_frame_writer: RTL and testbench

//  Downstream sink of the two-pixel RGB888 stream produced by the image-processing stage.

---
 rtl/image_pkg.sv | 55 +++++
 rtl/pair_addr_gen.sv | 61 ++++++
 rtl/bmp_frame_writer.sv | 144 ++++++++++++++
 tb/tb_bmp_frame_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared header for the frame-writer slice: FSM encodings, pair-word
// byte lanes, default geometry and small pixel-pair helpers.
package image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_t;

  localparam int PAIR_BYTES = 6;

  localparam int LANE_R0 = 0;
  localparam int LANE_G0 = 1;
  localparam int LANE_B0 = 2;
  localparam int LANE_R1 = 3;
  localparam int LANE_G1 = 4;
  localparam int LANE_B1 = 5;

  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_ADDR_W = 18;

  function automatic logic [47:0] pack_pair(
    input logic [7:0] r0,
    input logic [7:0] g0,
    input logic [7:0] b0,
    input logic [7:0] r1,
    input logic [7:0] g1,
    input logic [7:0] b1
  );
    logic [47:0] w;
    w = '0;
    w[8*LANE_R0 +: 8] = r0;
    w[8*LANE_G0 +: 8] = g0;
    w[8*LANE_B0 +: 8] = b0;
    w[8*LANE_R1 +: 8] = r1;
    w[8*LANE_G1 +: 8] = g1;
    w[8*LANE_B1 +: 8] = b1;
    return w;
  endfunction

  function automatic logic [31:0] pair_sum(
    input logic [47:0] w
  );
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < PAIR_BYTES; i++) begin
      s = s + {24'd0, w[8*i +: 8]};
    end
    return s;
  endfunction

endpackage

// File: rtl/pair_addr_gen.sv
// Pair-word address generator: col/row counters with row reversal.
// Ports: HCLK, HRESET, clr, step in; addr, last_pair out.
module pair_addr_gen #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pair
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [ADDR_W-1:0] TOP_BASE =
    ADDR_W'((HEIGHT - 1) * PAIRS);
  localparam logic [ADDR_W-1:0] ROW_STEP =
    ADDR_W'(PAIRS);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] base;
  logic              col_last;
  logic              row_last;

  assign col_last  = (col == CW'(PAIRS - 1));
  assign row_last  = (row == RW'(HEIGHT - 1));
  assign last_pair = col_last & row_last;

  // base tracks (HEIGHT-1-row)*PAIRS so no multiplier is needed
  assign addr = base + ADDR_W'(col);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      col  <= '0;
      row  <= '0;
      base <= TOP_BASE;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      base <= TOP_BASE;
    end else if (step) begin
      if (col_last) begin
        col <= '0;
        // last row holds; only a new frame restarts it
        if (!row_last) begin
          row  <= row + 1'b1;
          base <= base - ROW_STEP;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bmp_frame_writer.sv
// Frame capture sink: writes VSYNC/HSYNC framed pixel pairs bottom-up
// into a 48-bit frame-buffer port. Optional macro: PIXEL_SUM_EN.
// Ports: HCLK, HRESET, VSYNC, HSYNC, DATA_{R,G,B}{0,1} in;
//        wr_en, wr_addr, wr_data, write_done, frame_abort,
//        overrun, frame_sum out.
module bmp_frame_writer
  import image_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [47:0]       wr_data,
  output logic              write_done,
  output logic              frame_abort,
  output logic              overrun,
  output logic [31:0]       frame_sum
);

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic              do_write;
  logic              clr;
  logic              abort;
  logic              stray;
  logic [ADDR_W-1:0] addr;
  logic              last_pair;
  logic [47:0]       word;

  assign word = pack_pair(DATA_R0, DATA_G0, DATA_B0,
                          DATA_R1, DATA_G1, DATA_B1);

  pair_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .clr       (clr),
    .step      (do_write),
    .addr      (addr),
    .last_pair (last_pair)
  );

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    clr      = 1'b0;
    abort    = 1'b0;
    stray    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stray = HSYNC;
        if (VSYNC) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        stray = HSYNC;
        if (!VSYNC) begin
          state_d = ST_CAPTURE;
          clr     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // VSYNC outranks HSYNC: restart, drop the pair
        if (VSYNC) begin
          state_d = ST_ARMED;
          abort   = 1'b1;
        end else if (HSYNC) begin
          do_write = 1'b1;
          if (last_pair) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        stray = HSYNC;
        if (VSYNC) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      write_done  <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wr_en       <= do_write;
      frame_abort <= abort;
      if (do_write) begin
        wr_addr <= addr;
        wr_data <= word;
      end
      if (stray) overrun <= 1'b1;
      if (clr) begin
        write_done <= 1'b0;
      end else if (do_write && last_pair) begin
        write_done <= 1'b1;
      end
    end
  end

`ifdef PIXEL_SUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (do_write) begin
      sum_q <= sum_q + pair_sum(word);
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Randomized self-checking bench for bmp_frame_writer (8x4 frame).
// Reference model tracks frame progress as a plain pair count.
module tb_bmp_frame_writer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 4;
  localparam int LP    = W / 2;
  localparam int PAIRS = W * H / 2;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic          VSYNC = 1'b0;
  logic          HSYNC = 1'b0;
  logic [7:0]    DATA_R0 = '0;
  logic [7:0]    DATA_G0 = '0;
  logic [7:0]    DATA_B0 = '0;
  logic [7:0]    DATA_R1 = '0;
  logic [7:0]    DATA_G1 = '0;
  logic [7:0]    DATA_B1 = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [47:0]   wr_data;
  logic          write_done;
  logic          frame_abort;
  logic          overrun;
  logic [31:0]   frame_sum;

  int checks = 0;
  int errors = 0;

  bit          m_vs;
  bit          m_cap;
  bit          m_done;
  bit          m_ovr;
  int          m_n;
  logic [31:0] m_sum;
  bit          e_we;
  bit          e_ab;
  logic [AW-1:0] e_addr;
  logic [47:0] e_data;

  always #5 HCLK = ~HCLK;

  bmp_frame_writer #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .VSYNC       (VSYNC),
    .HSYNC       (HSYNC),
    .DATA_R0     (DATA_R0),
    .DATA_G0     (DATA_G0),
    .DATA_B0     (DATA_B0),
    .DATA_R1     (DATA_R1),
    .DATA_G1     (DATA_G1),
    .DATA_B1     (DATA_B1),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .write_done  (write_done),
    .frame_abort (frame_abort),
    .overrun     (overrun),
    .frame_sum   (frame_sum)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vs   = 0;
    m_cap  = 0;
    m_done = 0;
    m_ovr  = 0;
    m_n    = 0;
    m_sum  = '0;
    e_we   = 0;
    e_ab   = 0;
  endtask

  task automatic model_step();
    e_we = 0;
    e_ab = 0;
    if (m_cap) begin
      if (VSYNC) begin
        m_cap = 0;
        m_vs  = 1;
        e_ab  = 1;
      end else if (HSYNC) begin
        e_we   = 1;
        e_addr = AW'((H - 1 - m_n / LP) * LP + m_n % LP);
        e_data = {DATA_B1, DATA_G1, DATA_R1,
                  DATA_B0, DATA_G0, DATA_R0};
`ifdef PIXEL_SUM_EN
        m_sum = m_sum + DATA_R0 + DATA_G0 + DATA_B0
                      + DATA_R1 + DATA_G1 + DATA_B1;
`endif
        m_n++;
        if (m_n == PAIRS) begin
          m_cap  = 0;
          m_done = 1;
        end
      end
    end else begin
      if (HSYNC) m_ovr = 1;
      if (m_vs && !VSYNC) begin
        m_vs   = 0;
        m_cap  = 1;
        m_n    = 0;
        m_done = 0;
        m_sum  = '0;
      end else if (VSYNC) begin
        m_vs = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("wr_en", wr_en, e_we);
    if (e_we) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    chk("write_done", write_done, m_done);
    chk("frame_abort", frame_abort, e_ab);
    chk("overrun", overrun, m_ovr);
    chk("frame_sum", frame_sum, m_sum);
  endtask

  task automatic rand_data();
    DATA_R0 = 8'($urandom);
    DATA_G0 = 8'($urandom);
    DATA_B0 = 8'($urandom);
    DATA_R1 = 8'($urandom);
    DATA_G1 = 8'($urandom);
    DATA_B1 = 8'($urandom);
  endtask

  task automatic cyc(input bit v, input bit h);
    VSYNC = v;
    HSYNC = h;
    @(posedge HCLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, wr_en, 0);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_done"}, write_done, 0);
    chk({tag, "_abort"}, frame_abort, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_sum"}, frame_sum, 0);
  endtask

  // vs cycles of VSYNC, one quiet cycle, then n pairs with gaps
  task automatic run_frame(input int vs, input int n, input bit ff);
    for (int i = 0; i < vs; i++) cyc(1, 0);
    cyc(0, 0);
    for (int p = 0; p < n; p++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cyc(0, 0);
      if (!ff) rand_data();
      cyc(0, 1);
      if (p == 0) chk("first_addr", wr_addr, 12);
      if (p == PAIRS - 1) chk("last_addr", wr_addr, 3);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("rst");
    HRESET = 1'b1;

    cyc(0, 1);
    cyc(0, 1);
    chk("ovr_idle", overrun, 1);

    for (int i = 0; i < 3; i++) cyc(1, 0);
    cyc(0, 0);
    DATA_R0 = 8'h01; DATA_G0 = 8'h02; DATA_B0 = 8'h03;
    DATA_R1 = 8'h04; DATA_G1 = 8'h05; DATA_B1 = 8'h06;
    cyc(0, 1);
    chk("pair_data", wr_data, 48'h060504030201);
    chk("pair_addr0", wr_addr, 12);
    for (int p = 1; p < PAIRS; p++) begin
      if (p % 3 == 0) cyc(0, 0);
      chk("not_done_yet", write_done, 0);
      rand_data();
      cyc(0, 1);
    end
    chk("end_addr", wr_addr, 3);
    cyc(0, 0);
    chk("done_level", write_done, 1);
    cyc(0, 1);
    cyc(0, 0);

    run_frame(2, 5, 0);
    cyc(1, 0);
    chk("abort_pulse", frame_abort, 1);
    cyc(1, 0);
    chk("abort_low", frame_abort, 0);
    chk("abort_ndone", write_done, 0);
    run_frame(1, PAIRS, 0);
    cyc(0, 0);
    chk("refill_done", write_done, 1);
    chk("ovr_sticky", overrun, 1);

    run_frame(3, 6, 0);
    rand_data();
    VSYNC = 0;
    HSYNC = 1;
    #2;
    HRESET = 1'b0;
    #1;
    model_reset();
    check_zero("mid_rst");
    @(posedge HCLK);
    #1;
    check_zero("mid_rst2");
    HSYNC = 0;
    HRESET = 1'b1;
    run_frame(2, PAIRS, 0);
    cyc(0, 0);
    chk("post_rst_done", write_done, 1);

    DATA_R0 = 8'hFF; DATA_G0 = 8'hFF; DATA_B0 = 8'hFF;
    DATA_R1 = 8'hFF; DATA_G1 = 8'hFF; DATA_B1 = 8'hFF;
    run_frame(2, PAIRS, 1);
    cyc(0, 0);
`ifdef PIXEL_SUM_EN
    chk("sum_ff", frame_sum, 32'd24480);
`else
    chk("sum_off", frame_sum, 32'd0);
`endif
    cyc(0, 0);
    chk("sum_hold", frame_sum, m_sum);

    for (int i = 0; i < 800; i++) begin
      bit v;
      bit h;
      v = ($urandom_range(0, 99) < 3);
      h = $urandom_range(0, 1) == 1;
      rand_data();
      cyc(v, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
